// File: rtl/sdc_arb_pkg.sv
// Shared types and constants for the multi-port SDRAM host arbiter.
`timescale 1ns/1ps
package sdc_arb_pkg;

    localparam int MAX_PORTS = 8;
    localparam int GNT_W     = $clog2(MAX_PORTS);
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Next port index with an explicit wrap from n-1 back to 0.
    function automatic logic [GNT_W-1:0] wrap_inc(input logic [GNT_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/sdc_rr_pick.sv
// Combinational priority picker: first requester at or after ptr, wrapping.
`timescale 1ns/1ps
module sdc_rr_pick
    import sdc_arb_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0] req,
    input  logic [GNT_W-1:0]  ptr,
    output logic [NPORTS-1:0] gnt_oh,
    output logic [GNT_W-1:0]  gnt_idx,
    output logic              valid
);

    int cand;

    // Scan candidates ptr, ptr+1, ... and keep the first one that is requesting.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NPORTS) cand = cand - NPORTS;
            for (int j = 0; j < NPORTS; j++) begin
                if (!valid && cand == j && req[j]) begin
                    valid      = 1'b1;
                    gnt_oh[j]  = 1'b1;
                    gnt_idx    = GNT_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/sdc_port_arb.sv
// N-port host arbiter in front of the single SDRAM controller host port.
`timescale 1ns/1ps
module sdc_port_arb
    import sdc_arb_pkg::*;
#(
    parameter int NPORTS   = 4,
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                     mclk,
    input  logic                     s_reset,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS*ADDR_W-1:0] p_req_adr,
    input  logic [NPORTS*2-1:0]      p_req_len,
    input  logic [NPORTS-1:0]        p_req_wr_n,
    input  logic [NPORTS*DATA_W-1:0] p_wr_data,
    input  logic [NPORTS*BE_W-1:0]   p_wr_en_n,
    output logic [NPORTS-1:0]        p_req_ack,
    output logic [NPORTS-1:0]        p_wr_next,
    output logic [NPORTS-1:0]        p_rd_valid,
    output logic [DATA_W-1:0]        p_rd_data,
    output logic                     sdr_req,
    output logic [ADDR_W-1:0]        sdr_req_adr,
    output logic [1:0]               sdr_req_len,
    output logic                     sdr_req_wr_n,
    output logic [DATA_W-1:0]        sdr_wr_data,
    output logic [BE_W-1:0]          sdr_wr_en_n,
    input  logic                     sdr_req_ack,
    input  logic                     sdr_wr_next,
    input  logic                     sdr_rd_valid,
    input  logic [DATA_W-1:0]        sdr_rd_data,
    input  logic                     sdr_init_done,
    output logic                     arb_err,
    output logic [2:0]               arb_gnt
);

    arb_state_t        state, next_state;
    logic [GNT_W-1:0]  gnt, rr_ptr, pick_ptr, pick_idx;
    logic [NPORTS-1:0] pick_oh, gnt_oh;
    logic              pick_valid, grant_now, strobe, burst_done, gnt_req, err_set;
    logic [2:0]        beat_cnt;
    logic [ADDR_W-1:0] sel_adr;
    logic [1:0]        sel_len;
    logic              sel_wr_n;

    // Fixed priority is the round-robin picker with its pointer pinned at port 0.
    assign pick_ptr = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;

    sdc_rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req     (p_req),
        .ptr     (pick_ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign grant_now  = sdr_init_done && pick_valid;
    assign strobe     = sdr_wr_next || sdr_rd_valid;
    assign burst_done = (state == DATA) && strobe && (beat_cnt == 3'd1);
    assign gnt_req    = |(p_req & gnt_oh);
    assign p_rd_data  = sdr_rd_data;
    assign arb_gnt    = 3'(gnt);

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NPORTS; i++) gnt_oh[i] = (gnt == GNT_W'(i));
    end

    always_comb begin
        sel_adr  = '0;
        sel_len  = '0;
        sel_wr_n = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (pick_oh[i]) begin
                sel_adr  = p_req_adr[i*ADDR_W +: ADDR_W];
                sel_len  = p_req_len[i*2 +: 2];
                sel_wr_n = p_req_wr_n[i];
            end
        end
    end

    // Strobes outside DATA, wrong-type strobes, and a granted port dropping its request.
    assign err_set = (strobe && state != DATA)
                  || (state == DATA && ((sdr_rd_valid && !sdr_req_wr_n) || (sdr_wr_next && sdr_req_wr_n)))
                  || (state == REQ && !gnt_req);

    always_ff @(posedge mclk) begin
        if (s_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_now)   next_state = REQ;
            REQ:     if (sdr_req_ack) next_state = DATA;
            DATA:    if (burst_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        p_req_ack   = '0;
        p_wr_next   = '0;
        p_rd_valid  = '0;
        sdr_wr_data = '0;
        sdr_wr_en_n = '0;
        if (state == REQ && sdr_req_ack) p_req_ack = gnt_oh;
        if (state == DATA) begin
            if (sdr_wr_next)  p_wr_next  = gnt_oh;
            if (sdr_rd_valid) p_rd_valid = gnt_oh;
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt_oh[i]) begin
                    sdr_wr_data = p_wr_data[i*DATA_W +: DATA_W];
                    sdr_wr_en_n = p_wr_en_n[i*BE_W +: BE_W];
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (s_reset) begin
            gnt          <= '0;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            sdr_req      <= 1'b0;
            sdr_req_adr  <= '0;
            sdr_req_len  <= '0;
            sdr_req_wr_n <= 1'b0;
            arb_err      <= 1'b0;
        end else begin
            sdr_req <= (next_state == REQ);
            if (err_set) arb_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        gnt          <= pick_idx;
                        sdr_req_adr  <= sel_adr;
                        sdr_req_len  <= sel_len;
                        sdr_req_wr_n <= sel_wr_n;
                    end
                end
                REQ: begin
                    if (sdr_req_ack) beat_cnt <= {1'b0, sdr_req_len} + 3'd1;
                end
                DATA: begin
                    if (strobe) beat_cnt <= beat_cnt - 3'd1;
                    if (burst_done && ARB_MODE == ARB_RR) rr_ptr <= wrap_inc(gnt, NPORTS);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdc_port_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven in lockstep.
`timescale 1ns/1ps
module tb_sdc_port_arb;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int BW = 4;

    logic             mclk = 1'b0;
    logic             s_reset;
    logic [NP-1:0]    p_req;
    logic [NP*AW-1:0] p_req_adr;
    logic [NP*2-1:0]  p_req_len;
    logic [NP-1:0]    p_req_wr_n;
    logic [NP*DW-1:0] p_wr_data;
    logic [NP*BW-1:0] p_wr_en_n;
    logic             sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;
    logic [DW-1:0]    sdr_rd_data;

    logic [NP-1:0] p_req_ack, p_wr_next, p_rd_valid;
    logic [DW-1:0] p_rd_data, sdr_wr_data;
    logic          sdr_req, sdr_req_wr_n, arb_err;
    logic [AW-1:0] sdr_req_adr;
    logic [1:0]    sdr_req_len;
    logic [BW-1:0] sdr_wr_en_n;
    logic [2:0]    arb_gnt;

    logic [NP-1:0] fx_p_req_ack, fx_p_wr_next, fx_p_rd_valid;
    logic [DW-1:0] fx_p_rd_data, fx_sdr_wr_data;
    logic          fx_sdr_req, fx_sdr_req_wr_n, fx_arb_err;
    logic [AW-1:0] fx_sdr_req_adr;
    logic [1:0]    fx_sdr_req_len;
    logic [BW-1:0] fx_sdr_wr_en_n;
    logic [2:0]    fx_arb_gnt;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int grant_cnt [NP];
    logic seen;

    always #5 mclk = ~mclk;

    sdc_port_arb #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .ARB_MODE(0)) dut (
        .mclk(mclk), .s_reset(s_reset), .p_req(p_req), .p_req_adr(p_req_adr),
        .p_req_len(p_req_len), .p_req_wr_n(p_req_wr_n), .p_wr_data(p_wr_data),
        .p_wr_en_n(p_wr_en_n), .p_req_ack(p_req_ack), .p_wr_next(p_wr_next),
        .p_rd_valid(p_rd_valid), .p_rd_data(p_rd_data), .sdr_req(sdr_req),
        .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len), .sdr_req_wr_n(sdr_req_wr_n),
        .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n), .sdr_req_ack(sdr_req_ack),
        .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid), .sdr_rd_data(sdr_rd_data),
        .sdr_init_done(sdr_init_done), .arb_err(arb_err), .arb_gnt(arb_gnt)
    );

    sdc_port_arb #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .ARB_MODE(1)) dut_fx (
        .mclk(mclk), .s_reset(s_reset), .p_req(p_req), .p_req_adr(p_req_adr),
        .p_req_len(p_req_len), .p_req_wr_n(p_req_wr_n), .p_wr_data(p_wr_data),
        .p_wr_en_n(p_wr_en_n), .p_req_ack(fx_p_req_ack), .p_wr_next(fx_p_wr_next),
        .p_rd_valid(fx_p_rd_valid), .p_rd_data(fx_p_rd_data), .sdr_req(fx_sdr_req),
        .sdr_req_adr(fx_sdr_req_adr), .sdr_req_len(fx_sdr_req_len), .sdr_req_wr_n(fx_sdr_req_wr_n),
        .sdr_wr_data(fx_sdr_wr_data), .sdr_wr_en_n(fx_sdr_wr_en_n), .sdr_req_ack(sdr_req_ack),
        .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid), .sdr_rd_data(sdr_rd_data),
        .sdr_init_done(sdr_init_done), .arb_err(fx_arb_err), .arb_gnt(fx_arb_gnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [NP-1:0] req, input logic ack, input logic wn, input logic rv);
        p_req        = req;
        sdr_req_ack  = ack;
        sdr_wr_next  = wn;
        sdr_rd_valid = rv;
        #1;
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] adr, input logic [1:0] len, input logic wr_n);
        p_req_adr[i*AW +: AW] = adr;
        p_req_len[i*2 +: 2]   = len;
        p_req_wr_n[i]         = wr_n;
    endtask

    task automatic do_reset();
        s_reset = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        s_reset = 1'b0;
        #1;
    endtask

    // Entered one cycle into REQ; ack after two REQ cycles, one read beat, one IDLE cycle.
    task automatic run_read_grant(input int exp_rr, input int exp_fx, input logic [NP-1:0] next_req);
        checkOutput("req_up", 32'(sdr_req), 1);
        checkOutput("rr_gnt", 32'(arb_gnt), exp_rr);
        checkOutput("fx_gnt", 32'(fx_arb_gnt), exp_fx);
        tick();
        applyStimulus(p_req, 1'b1, 1'b0, 1'b0);
        checkOutput("rr_ack", 32'(p_req_ack), 1 << exp_rr);
        checkOutput("fx_ack", 32'(fx_p_req_ack), 1 << exp_fx);
        tick();
        applyStimulus(next_req, 1'b0, 1'b0, 1'b1);
        checkOutput("rr_rdv", 32'(p_rd_valid), 1 << exp_rr);
        checkOutput("req_down", 32'(sdr_req), 0);
        tick();
        applyStimulus(next_req, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        s_reset       = 1'b1;
        sdr_init_done = 1'b0;
        sdr_rd_data   = 32'hDEADBEEF;
        p_req_adr     = '0;
        p_req_len     = '0;
        p_req_wr_n    = '0;
        p_wr_data     = '0;
        p_wr_en_n     = '0;
        for (int i = 0; i < NP; i++) begin
            set_port(i, AW'(32'h100 + 32'(i)), 2'd0, 1'b1);
            p_wr_data[i*DW +: DW] = 32'hF0 + 32'(i);
            p_wr_en_n[i*BW +: BW] = 4'hF;
            grant_cnt[i] = 0;
        end
        do_reset();

        checkOutput("rst_sdr_req", 32'(sdr_req), 0);
        checkOutput("rst_gnt", 32'(arb_gnt), 0);
        checkOutput("rst_err", 32'(arb_err), 0);
        checkOutput("rst_ack", 32'(p_req_ack), 0);
        checkOutput("rst_adr", 32'(sdr_req_adr), 0);
        checkOutput("rst_wdata", sdr_wr_data, 0);
        checkOutput("rd_pass", p_rd_data, 32'hDEADBEEF);
        checkOutput("fx_rst", 32'(|{fx_p_req_ack, fx_p_wr_next, fx_p_rd_valid, fx_sdr_wr_data,
                    fx_sdr_req, fx_sdr_req_wr_n, fx_arb_err, fx_sdr_req_adr, fx_sdr_req_len,
                    fx_sdr_wr_en_n, fx_arb_gnt}), 0);
        checkOutput("fx_rd_pass", fx_p_rd_data, 32'hDEADBEEF);

        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (sdr_req || fx_sdr_req) seen = 1'b1;
        end
        checkOutput("init_gate", 32'(seen), 0);

        sdr_init_done = 1'b1;
        tick();
        checkOutput("init_adr", 32'(sdr_req_adr), 32'h100);
        for (int g = 0; g < 100; g++) begin
            if (arb_gnt < 3'd4) grant_cnt[arb_gnt[1:0]]++;
            run_read_grant(g % 4, 0, 4'hF);
        end
        for (int i = 0; i < NP; i++) checkOutput($sformatf("fair_%0d", i), 32'(grant_cnt[i]), 25);
        do_reset();

        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
        tick();
        run_read_grant(1, 1, 4'b1010);
        run_read_grant(3, 1, 4'b1010);
        run_read_grant(1, 1, 4'b1000);
        run_read_grant(3, 3, 4'b0000);
        checkOutput("fix_idle", 32'(sdr_req), 0);
        checkOutput("fix_err", 32'(arb_err), 0);
        checkOutput("fix_fx_err", 32'(fx_arb_err), 0);

        set_port(2, 23'h102, 2'd3, 1'b0);
        p_wr_en_n[2*BW +: BW] = 4'h5;
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("wr_gnt", 32'(arb_gnt), 2);
        checkOutput("wr_len", 32'(sdr_req_len), 3);
        checkOutput("wr_wrn", 32'(sdr_req_wr_n), 0);
        checkOutput("wr_adr", 32'(sdr_req_adr), 32'h102);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        checkOutput("wr_ack", 32'(p_req_ack), 32'b0100);
        tick();
        for (int b = 0; b < 4; b++) begin
            p_wr_data[2*DW +: DW] = 32'hA0 + 32'(b);
            applyStimulus('0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("wr_data_%0d", b), sdr_wr_data, 32'hA0 + 32'(b));
            checkOutput($sformatf("wr_next_%0d", b), 32'(p_wr_next), 32'b0100);
            if (b == 0) checkOutput("wr_en_n", 32'(sdr_wr_en_n), 32'h5);
            tick();
        end
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_done_err", 32'(arb_err), 0);

        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_rdv_blocked", 32'(p_rd_valid), 0);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_rdv_err", 32'(arb_err), 1);
        repeat (3) tick();
        checkOutput("err_sticky", 32'(arb_err), 1);
        do_reset();
        checkOutput("err_cleared", 32'(arb_err), 0);

        set_port(0, 23'h100, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        checkOutput("mis_fwd", 32'(p_wr_next), 32'b0001);
        checkOutput("mis_err_pre", 32'(arb_err), 0);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("mis_err", 32'(arb_err), 1);
        do_reset();

        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("drop_err", 32'(arb_err), 1);
        checkOutput("drop_req", 32'(sdr_req), 1);
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_ack", 32'(p_req_ack), 32'b0001);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        checkOutput("drop_rdv", 32'(p_rd_valid), 32'b0001);
        tick();
        do_reset();

        set_port(2, 23'h102, 2'd0, 1'b1);
        set_port(1, 23'h101, 2'd3, 1'b1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mb_gnt", 32'(arb_gnt), 1);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        checkOutput("mb_beat1", 32'(p_rd_valid), 32'b0010);
        tick();
        s_reset = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        tick();
        s_reset = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        checkOutput("mb_no_fwd", 32'(p_rd_valid), 0);
        checkOutput("mb_sdr_req", 32'(sdr_req), 0);
        checkOutput("mb_gnt_rst", 32'(arb_gnt), 0);
        checkOutput("mb_err_rst", 32'(arb_err), 0);
        checkOutput("mb_adr_rst", 32'(sdr_req_adr), 0);
        tick();
        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mb_ptr_rst", 32'(arb_gnt), 1);
        checkOutput("mb_fx_gnt", 32'(fx_arb_gnt), 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
